adda_seq: RTL and testbench

//  Sequencer for the shared address-A adder operand mux in the blitter address unit.
//  Per pixel and per line end, it time-multiplexes the adder between A1 and A2 pointer updates.
//  It drives addasel/adda_xconst/adda_yconst/addareg/suba_x/suba_y plus one-cycle write strobes.

---
 rtl/adda_if.sv | 52 +++++
 rtl/adda_seq.sv | 208 ++++++++++++++++++++
 tb/tb_adda_seq.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adda_if.sv
// Command/status bundle between blitter control and the address-A adder sequencer.
// master = blitter control side, slave = adda_seq.
interface adda_if #(
   parameter int CNT_W = 16
);
   logic             start;
   logic             stop;
   logic [CNT_W-1:0] inner_cnt;
   logic [CNT_W-1:0] outer_cnt;
   logic [1:0]       a1_xadd;
   logic             a1_yadd;
   logic             a1_xsign;
   logic             a1_ysign;
   logic [1:0]       a2_xadd;
   logic             a2_yadd;
   logic             a2_xsign;
   logic             a2_ysign;
   logic [2:0]       phr_const;
   logic             pix_go;
   logic             ready;
   logic [2:0]       addasel;
   logic [2:0]       adda_xconst;
   logic             adda_yconst;
   logic             addareg;
   logic             suba_x;
   logic             suba_y;
   logic             a1_upd;
   logic             a1f_upd;
   logic             a2_upd;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, inner_cnt, outer_cnt,
      output a1_xadd, a1_yadd, a1_xsign, a1_ysign,
      output a2_xadd, a2_yadd, a2_xsign, a2_ysign,
      output phr_const, pix_go,
      input  ready, addasel, adda_xconst, adda_yconst,
      input  addareg, suba_x, suba_y,
      input  a1_upd, a1f_upd, a2_upd, busy, done
   );

   modport slave (
      input  start, stop, inner_cnt, outer_cnt,
      input  a1_xadd, a1_yadd, a1_xsign, a1_ysign,
      input  a2_xadd, a2_yadd, a2_xsign, a2_ysign,
      input  phr_const, pix_go,
      output ready, addasel, adda_xconst, adda_yconst,
      output addareg, suba_x, suba_y,
      output a1_upd, a1f_upd, a2_upd, busy, done
   );
endinterface

// File: rtl/adda_seq.sv
// Address-A adder sequencer: time-multiplexes the shared adder between A1/A2 updates.
// ADDA_FRAC_EN enables the A1 fraction update states (P_A1F, L_A1F).
module adda_seq #(
   parameter int CNT_W = 16
) (
   input logic  sys_clk,
   input logic  resetl,
   adda_if.slave bus
);

   typedef enum logic [3:0] {
      IDLE, WAIT, P_A1,
`ifdef ADDA_FRAC_EN
      P_A1F, L_A1F,
`endif
      P_A2, L_A1, L_A2, DONE
   } state_t;

   typedef struct packed {
      logic       ready;
      logic [2:0] addasel;
      logic [2:0] xconst;
      logic       yconst;
      logic       addareg;
      logic       suba_x;
      logic       suba_y;
      logic       a1_upd;
      logic       a1f_upd;
      logic       a2_upd;
      logic       busy;
      logic       done;
   } ctl_t;

   state_t           state, nxt, pend;
   ctl_t             ctl, ctl_n;
   logic [CNT_W-1:0] icnt, ild, ocnt;
   logic [1:0]       a1m, a2m;
   logic             a1y, a1xs, a1ys;
   logic             a2y, a2xs, a2ys;
   logic [2:0]       phr;
   logic             pix_end;
   logic             a2_skip;
   logic             icnt_last;

   assign a2_skip   = a2m[1];
   assign icnt_last = (icnt == CNT_W'(1));
   assign pend      = icnt_last ? L_A1 : WAIT;

   always_comb begin
      nxt     = state;
      pix_end = 1'b0;
      unique case (state)
         IDLE: if (bus.start) nxt = WAIT;
         WAIT: begin
            if (bus.pix_go) begin
               if (a1m != 2'b10) nxt = P_A1;
               else if (!a2_skip) nxt = P_A2;
               else begin
                  nxt     = pend;
                  pix_end = 1'b1;
               end
            end
         end
         P_A1: begin
            if (!a2_skip) nxt = P_A2;
            else begin
               nxt     = pend;
               pix_end = 1'b1;
            end
`ifdef ADDA_FRAC_EN
            if (a1m == 2'b11) begin
               nxt     = P_A1F;
               pix_end = 1'b0;
            end
`endif
         end
`ifdef ADDA_FRAC_EN
         P_A1F: begin
            if (!a2_skip) nxt = P_A2;
            else begin
               nxt     = pend;
               pix_end = 1'b1;
            end
         end
         L_A1:  nxt = L_A1F;
         L_A1F: nxt = L_A2;
`else
         L_A1:  nxt = L_A2;
`endif
         P_A2: begin
            nxt     = pend;
            pix_end = 1'b1;
         end
         L_A2: nxt = (ocnt == CNT_W'(1)) ? DONE : WAIT;
         DONE: nxt = IDLE;
         default: nxt = IDLE;
      endcase
      // abort wins over every other event this cycle
      if (bus.stop) begin
         nxt     = IDLE;
         pix_end = 1'b0;
      end
   end

   always_comb begin
      ctl_n       = '0;
      ctl_n.ready = (nxt == WAIT);
      ctl_n.busy  = (nxt != IDLE);
      ctl_n.done  = (nxt == DONE);
      unique case (nxt)
         P_A1: begin
            ctl_n.a1_upd = 1'b1;
            ctl_n.suba_x = a1xs;
            ctl_n.suba_y = a1ys;
            if (a1m == 2'b11) ctl_n.addareg = 1'b1;
            else begin
               ctl_n.xconst = a1m[0] ? 3'b000 : phr;
               ctl_n.yconst = a1y;
            end
         end
`ifdef ADDA_FRAC_EN
         // fraction half of the same signed increment
         P_A1F: begin
            ctl_n.addareg = 1'b1;
            ctl_n.addasel = 3'b001;
            ctl_n.a1f_upd = 1'b1;
            ctl_n.suba_x  = a1xs;
            ctl_n.suba_y  = a1ys;
         end
         L_A1F: begin
            ctl_n.addareg = 1'b1;
            ctl_n.addasel = 3'b011;
            ctl_n.a1f_upd = 1'b1;
         end
`endif
         P_A2: begin
            ctl_n.a2_upd = 1'b1;
            ctl_n.suba_x = a2xs;
            ctl_n.suba_y = a2ys;
            ctl_n.xconst = a2m[0] ? 3'b000 : phr;
            ctl_n.yconst = a2y;
         end
         L_A1: begin
            ctl_n.addareg = 1'b1;
            ctl_n.addasel = 3'b010;
            ctl_n.a1_upd  = 1'b1;
         end
         L_A2: begin
            ctl_n.addareg = 1'b1;
            ctl_n.addasel = 3'b100;
            ctl_n.a2_upd  = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge sys_clk or negedge resetl) begin
      if (!resetl) begin
         state <= IDLE;
         ctl   <= '0;
         icnt  <= '0;
         ild   <= '0;
         ocnt  <= '0;
         a1m   <= '0;
         a1y   <= 1'b0;
         a1xs  <= 1'b0;
         a1ys  <= 1'b0;
         a2m   <= '0;
         a2y   <= 1'b0;
         a2xs  <= 1'b0;
         a2ys  <= 1'b0;
         phr   <= '0;
      end else begin
         state <= nxt;
         ctl   <= ctl_n;
         if (state == IDLE && bus.start && !bus.stop) begin
            icnt <= (bus.inner_cnt == '0) ? CNT_W'(1) : bus.inner_cnt;
            ild  <= (bus.inner_cnt == '0) ? CNT_W'(1) : bus.inner_cnt;
            ocnt <= (bus.outer_cnt == '0) ? CNT_W'(1) : bus.outer_cnt;
            a1m  <= bus.a1_xadd;
            a1y  <= bus.a1_yadd;
            a1xs <= bus.a1_xsign;
            a1ys <= bus.a1_ysign;
            a2m  <= bus.a2_xadd;
            a2y  <= bus.a2_yadd;
            a2xs <= bus.a2_xsign;
            a2ys <= bus.a2_ysign;
            phr  <= bus.phr_const;
         end
         if (pix_end) icnt <= icnt_last ? ild : icnt - CNT_W'(1);
         if (state == L_A2 && !bus.stop) ocnt <= ocnt - CNT_W'(1);
      end
   end

   assign bus.ready       = ctl.ready;
   assign bus.addasel     = ctl.addasel;
   assign bus.adda_xconst = ctl.xconst;
   assign bus.adda_yconst = ctl.yconst;
   assign bus.addareg     = ctl.addareg;
   assign bus.suba_x      = ctl.suba_x;
   assign bus.suba_y      = ctl.suba_y;
   assign bus.a1_upd      = ctl.a1_upd;
   assign bus.a1f_upd     = ctl.a1f_upd;
   assign bus.a2_upd      = ctl.a2_upd;
   assign bus.busy        = ctl.busy;
   assign bus.done        = ctl.done;

endmodule

// File: tb/tb_adda_seq.sv
// Bench for adda_seq: builds the expected per-cycle output trace of each blit
// from the pixel/line rules, drives matching stimulus, compares every cycle.
module tb_adda_seq;
   localparam int CNT_W = 16;
`ifdef ADDA_FRAC_EN
   localparam bit FRAC = 1'b1;
`else
   localparam bit FRAC = 1'b0;
`endif

   typedef logic [15:0] vec_t;

   logic sys_clk = 1'b0;
   logic resetl  = 1'b0;

   adda_if #(.CNT_W(CNT_W)) bus ();

   adda_seq #(.CNT_W(CNT_W)) dut (
      .sys_clk(sys_clk),
      .resetl (resetl),
      .bus    (bus)
   );

   always #5 sys_clk = ~sys_clk;

   int   checks = 0;
   int   errors = 0;
   vec_t exp_q[$];
   vec_t V[$];
   bit   G[$];
   int   line_idx;
   int   n_a1, n_a1f, n_a2, n_done;

   logic [1:0] c_a1m, c_a2m;
   bit         c_a1y, c_a1xs, c_a1ys, c_a2y, c_a2xs, c_a2ys;
   logic [2:0] c_phr;

   function automatic vec_t obs();
      return {bus.ready, bus.addasel, bus.adda_xconst, bus.adda_yconst,
              bus.addareg, bus.suba_x, bus.suba_y, bus.a1_upd,
              bus.a1f_upd, bus.a2_upd, bus.busy, bus.done};
   endfunction

   function automatic vec_t v(bit rdy, bit [2:0] sel, bit [2:0] xc, bit yc,
                              bit rg, bit sx, bit sy, bit u1, bit u1f,
                              bit u2, bit bsy, bit dn);
      return {rdy, sel, xc, yc, rg, sx, sy, u1, u1f, u2, bsy, dn};
   endfunction

   localparam vec_t V_IDLE = 16'h0000;
   localparam vec_t V_WAIT = 16'h8002;
   localparam vec_t V_DONE = 16'h0003;

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   always @(posedge sys_clk) begin
      #1;
      if (exp_q.size() > 0) chk("cycle", obs(), exp_q.pop_front());
      if (bus.a1_upd === 1'b1) n_a1++;
      if (bus.a1f_upd === 1'b1) n_a1f++;
      if (bus.a2_upd === 1'b1) n_a2++;
      if (bus.done === 1'b1) n_done++;
   end

   task automatic set_cfg(logic [1:0] a1m, bit a1y, bit a1xs, bit a1ys,
                          logic [1:0] a2m, bit a2y, bit a2xs, bit a2ys,
                          logic [2:0] phr);
      c_a1m = a1m; c_a1y = a1y; c_a1xs = a1xs; c_a1ys = a1ys;
      c_a2m = a2m; c_a2y = a2y; c_a2xs = a2xs; c_a2ys = a2ys;
      c_phr = phr;
   endtask

   task automatic push(vec_t x, bit g);
      V.push_back(x);
      G.push_back(g);
   endtask

   // adder uses of one pixel, in order
   task automatic add_pixel();
      if (c_a1m == 2'b11) begin
         push(v(0, 3'b000, 3'b000, 0, 1, c_a1xs, c_a1ys, 1, 0, 0, 1, 0),
              1'($urandom_range(0, 1)));
         if (FRAC)
            push(v(0, 3'b001, 3'b000, 0, 1, c_a1xs, c_a1ys, 0, 1, 0, 1, 0),
                 1'($urandom_range(0, 1)));
      end else if (c_a1m != 2'b10) begin
         push(v(0, 3'b000, c_a1m[0] ? 3'b000 : c_phr, c_a1y, 0,
                c_a1xs, c_a1ys, 1, 0, 0, 1, 0), 1'($urandom_range(0, 1)));
      end
      if (!c_a2m[1])
         push(v(0, 3'b000, c_a2m[0] ? 3'b000 : c_phr, c_a2y, 0,
                c_a2xs, c_a2ys, 0, 0, 1, 1, 0), 1'($urandom_range(0, 1)));
   endtask

   task automatic build(int inner, int outer, bit gaps);
      int ni, no;
      ni = (inner == 0) ? 1 : inner;
      no = (outer == 0) ? 1 : outer;
      V.delete();
      G.delete();
      line_idx = -1;
      for (int l = 0; l < no; l++) begin
         for (int p = 0; p < ni; p++) begin
            for (int g = 0; g < (gaps ? p % 3 : 0); g++) push(V_WAIT, 1'b0);
            push(V_WAIT, 1'b1);
            add_pixel();
         end
         if (line_idx < 0) line_idx = V.size();
         push(v(0, 3'b010, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0), 1'($urandom_range(0, 1)));
         if (FRAC)
            push(v(0, 3'b011, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0), 1'($urandom_range(0, 1)));
         push(v(0, 3'b100, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0), 1'($urandom_range(0, 1)));
      end
      push(V_DONE, 1'($urandom_range(0, 1)));
   endtask

   task automatic scramble();
      bus.a1_xadd   = 2'($urandom);
      bus.a1_yadd   = 1'($urandom);
      bus.a1_xsign  = 1'($urandom);
      bus.a1_ysign  = 1'($urandom);
      bus.a2_xadd   = 2'($urandom);
      bus.a2_yadd   = 1'($urandom);
      bus.a2_xsign  = 1'($urandom);
      bus.a2_ysign  = 1'($urandom);
      bus.phr_const = 3'($urandom);
      bus.inner_cnt = CNT_W'($urandom);
      bus.outer_cnt = CNT_W'($urandom);
   endtask

   task automatic start_blit(int inner, int outer);
      @(negedge sys_clk);
      bus.start     = 1'b1;
      bus.stop      = 1'b0;
      bus.pix_go    = 1'b0;
      bus.a1_xadd   = c_a1m;
      bus.a1_yadd   = c_a1y;
      bus.a1_xsign  = c_a1xs;
      bus.a1_ysign  = c_a1ys;
      bus.a2_xadd   = c_a2m;
      bus.a2_yadd   = c_a2y;
      bus.a2_xsign  = c_a2xs;
      bus.a2_ysign  = c_a2ys;
      bus.phr_const = c_phr;
      bus.inner_cnt = CNT_W'(inner);
      bus.outer_cnt = CNT_W'(outer);
      exp_q.push_back(V_WAIT);
   endtask

   // stop_at: trace index during which stop is raised, -1 for none
   task automatic run(int inner, int outer, bit gaps, int stop_at);
      n_a1 = 0; n_a1f = 0; n_a2 = 0; n_done = 0;
      build(inner, outer, gaps);
      start_blit(inner, outer);
      for (int i = 1; i < V.size(); i++) begin
         @(negedge sys_clk);
         scramble();
         bus.start  = 1'($urandom_range(0, 1));
         bus.pix_go = G[i-1];
         if (i - 1 == stop_at) begin
            bus.stop   = 1'b1;
            bus.pix_go = 1'b1;
            exp_q.push_back(V_IDLE);
            break;
         end
         exp_q.push_back(V[i]);
      end
      for (int k = 0; k < 4; k++) begin
         @(negedge sys_clk);
         bus.start  = (k == 1);
         bus.stop   = (k == 1);
         bus.pix_go = 1'($urandom_range(0, 1));
         exp_q.push_back(V_IDLE);
      end
      @(negedge sys_clk);
      bus.start  = 1'b0;
      bus.stop   = 1'b0;
      bus.pix_go = 1'b0;
      chk("queue drained", exp_q.size(), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start = 0; bus.stop = 0; bus.pix_go = 0;
      set_cfg(2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 3'b000);
      scramble();
      repeat (2) @(posedge sys_clk);
      #1;
      chk("reset outputs", obs(), V_IDLE);
      @(negedge sys_clk);
      resetl = 1'b1;

      // 01/01 blit, 3 pixels x 1 line
      set_cfg(2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 3'b101);
      run(3, 1, 0, -1);
      chk("A trace length", V.size(), FRAC ? 13 : 12);
      chk("A P_A1 vector", V[1], 16'h0012);
      chk("A P_A2 vector", V[2], 16'h0006);
      chk("A L_A1 vector", V[9], 16'h2092);
      chk("A L_A2 vector", V[V.size()-2], 16'h4086);
      chk("A a1 strobes", n_a1, 4);
      chk("A a1f strobes", n_a1f, FRAC ? 1 : 0);
      chk("A a2 strobes", n_a2, 4);
      chk("A done pulses", n_done, 1);

      // mode 11 with signs, 1 pixel x 2 lines
      set_cfg(2'b11, 0, 1, 1, 2'b01, 1, 1, 0, 3'b010);
      run(1, 2, 0, -1);
      chk("B P_A1 vector", V[1], 16'h00F2);
      chk("B a1 strobes", n_a1, 4);
      chk("B a1f strobes", n_a1f, FRAC ? 4 : 0);
      chk("B a2 strobes", n_a2, 4);
      chk("B done pulses", n_done, 1);

      // both pointers in zero mode, 2 pixels, gaps between pix_go
      set_cfg(2'b10, 1, 1, 1, 2'b10, 1, 1, 1, 3'b111);
      run(2, 1, 1, -1);
      chk("C a1 strobes", n_a1, 1);
      chk("C a2 strobes", n_a2, 1);
      chk("C done pulses", n_done, 1);

      // abort during L_A1 with pix_go high
      set_cfg(2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 3'b000);
      run(3, 1, 0, 9);
      chk("D stop index", line_idx, 9);
      chk("D a1 strobes", n_a1, 4);
      chk("D a2 strobes", n_a2, 3);
      chk("D done pulses", n_done, 0);

      // phrase mode, zero counts treated as one
      set_cfg(2'b00, 1, 0, 1, 2'b00, 1, 1, 0, 3'b110);
      run(0, 0, 0, -1);
      chk("E P_A1 vector", V[1], 16'h0D32);
      chk("E done pulses", n_done, 1);

      // larger blit with gaps
      set_cfg(2'b11, 1, 1, 0, 2'b00, 0, 0, 1, 3'b011);
      run(5, 3, 1, -1);
      chk("F a2 strobes", n_a2, 18);
      chk("F done pulses", n_done, 1);

      // reset in the middle of P_A1
      set_cfg(2'b01, 0, 0, 0, 2'b01, 0, 0, 0, 3'b000);
      start_blit(3, 1);
      @(negedge sys_clk);
      bus.start  = 1'b0;
      bus.pix_go = 1'b1;
      exp_q.push_back(16'h0012);
      @(posedge sys_clk);
      #2;
      resetl = 1'b0;
      #1;
      chk("mid reset outputs", obs(), V_IDLE);
      chk("mid reset busy", bus.busy, 0);
      @(negedge sys_clk);
      resetl     = 1'b1;
      bus.pix_go = 1'b1;
      exp_q.push_back(V_IDLE);
      @(negedge sys_clk);
      bus.pix_go = 1'b0;
      chk("post reset drained", exp_q.size(), 0);

      // blit still works after reset
      set_cfg(2'b00, 0, 1, 0, 2'b01, 1, 0, 1, 3'b001);
      run(2, 2, 1, -1);
      chk("G done pulses", n_done, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
